gpu16_cmd_queue: RTL and testbench

Command queue and issue sequencer directly upstream of the GPU16 core. Buffers up to DEPTH complete GPU commands written by the CPU: instruction, data word, gpc start/index values, increment amounts and repeat count. Each command is presented to GPU16 with a one-cycle gpu_start pulse, and the block holds every operand stable until GPU16 finishes. The CPU can therefore queue a VRAM load, MRAM transfer and matrix ops back-to-back without polling busy.

---
 rtl/gpu16_pkg.sv | 15 +
 rtl/gpu16_cmd_fifo.sv | 30 +++
 rtl/gpu16_cmd_queue.sv | 105 ++++++++++
 tb/tb_gpu16_cmd_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu16_pkg.sv
// gpu16_pkg: command record, sequencer states and opcodes shared by the GPU16 command queue.
package gpu16_pkg;
  localparam logic [4:0] GPU16_OP_NOP = 5'd0;
  typedef struct packed {
    logic [4:0]  instruction;
    logic [15:0] data;
    logic [12:0] gpc_s;
    logic [12:0] gpc_i;
    logic [7:0]  inc_a;
    logic [7:0]  inc_b;
    logic [7:0]  repeat_amount;
  } gpu16_cmd_t;
  localparam int GPU16_CMD_W = $bits(gpu16_cmd_t);
  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT_BUSY, ST_WAIT_DONE} gpu16_cmdq_state_t;
endpackage

// File: rtl/gpu16_cmd_fifo.sv
// gpu16_cmd_fifo: DEPTH-entry command FIFO with head look-ahead; caller guards push/pop against full/empty.
module gpu16_cmd_fifo import gpu16_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [GPU16_CMD_W-1:0]   din,
  output logic [GPU16_CMD_W-1:0]   head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [GPU16_CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/gpu16_cmd_queue.sv
// gpu16_cmd_queue: buffers CPU commands and issues them to GPU16 one at a time with a start pulse.
// Optional GPU16_CMDQ_STATS_EN adds issued_count and timeout_count.
module gpu16_cmd_queue import gpu16_pkg::*; #(
  parameter int DEPTH     = 4,
  parameter int BUSY_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [4:0]             cmd_instruction,
  input  logic [15:0]            cmd_data,
  input  logic [12:0]            cmd_gpc_s,
  input  logic [12:0]            cmd_gpc_i,
  input  logic [7:0]             cmd_inc_a,
  input  logic [7:0]             cmd_inc_b,
  input  logic [7:0]             cmd_repeat,
  input  logic                   busy,
  output logic                   gpu_start,
  output logic [4:0]             instruction,
  output logic [15:0]            cpu_data,
  output logic [12:0]            gpc_val_s,
  output logic [12:0]            gpc_val_i,
  output logic [7:0]             gpc_inc_amount_a,
  output logic [7:0]             gpc_inc_amount_b,
  output logic [7:0]             repeat_op_amount,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic                   idle
`ifdef GPU16_CMDQ_STATS_EN
  ,
  output logic [15:0]            issued_count,
  output logic [7:0]             timeout_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(BUSY_WAIT + 1);
  gpu16_cmdq_state_t state;
  gpu16_cmd_t in_cmd, head, cur;
  logic [GPU16_CMD_W-1:0] head_bits;
  logic [WW-1:0] wait_cnt;
  logic [CW-1:0] count_n;
  logic push, pop, issue, timeout, to_idle;
  assign in_cmd = {cmd_instruction, cmd_data, cmd_gpc_s, cmd_gpc_i, cmd_inc_a, cmd_inc_b, cmd_repeat};
  assign head = head_bits;
  assign cmd_ready = queue_count < CW'(DEPTH);
  assign push = cmd_valid && cmd_ready;
  assign pop = state == ST_IDLE && queue_count != '0;
  assign issue = pop && head.instruction != GPU16_OP_NOP;
  assign timeout = state == ST_WAIT_BUSY && !busy && wait_cnt == WW'(BUSY_WAIT - 1);
  assign count_n = queue_count + CW'(push) - CW'(pop);
  // Sequencer will sit in IDLE after this edge: a NOP/empty IDLE, a busy timeout or busy falling.
  assign to_idle = (state == ST_IDLE && !issue) || timeout || (state == ST_WAIT_DONE && !busy);
  gpu16_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_cmd),
    .head  (head_bits),
    .count (queue_count)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      gpu_start <= 1'b0;
      idle      <= 1'b1;
      cur       <= '0;
    end else begin
      gpu_start <= issue;
      idle      <= to_idle && count_n == '0;
      case (state)
        ST_IDLE: if (issue) begin
          cur   <= head;
          state <= ST_START;
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY:
          if (busy) state <= ST_WAIT_DONE;
          else if (timeout) state <= ST_IDLE;
          else wait_cnt <= wait_cnt + 1'b1;
        default: if (!busy) state <= ST_IDLE;
      endcase
    end
  assign instruction      = cur.instruction;
  assign cpu_data         = cur.data;
  assign gpc_val_s        = cur.gpc_s;
  assign gpc_val_i        = cur.gpc_i;
  assign gpc_inc_amount_a = cur.inc_a;
  assign gpc_inc_amount_b = cur.inc_b;
  assign repeat_op_amount = cur.repeat_amount;
`ifdef GPU16_CMDQ_STATS_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      issued_count  <= '0;
      timeout_count <= '0;
    end else begin
      if (gpu_start) issued_count <= issued_count + 1'b1;
      if (timeout && timeout_count != 8'hFF) timeout_count <= timeout_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_gpu16_cmd_queue.sv
// tb_gpu16_cmd_queue: directed stimulus for gpu16_cmd_queue checked every cycle against a queue-based model.
module tb_gpu16_cmd_queue;
  import gpu16_pkg::*;
  localparam int DEPTH = 4;
  localparam int BUSY_WAIT = 4;
  logic clk = 0;
  logic reset = 0;
  logic cmd_valid = 0;
  logic [4:0] cmd_instruction = '0;
  logic [15:0] cmd_data = '0;
  logic [12:0] cmd_gpc_s = '0, cmd_gpc_i = '0;
  logic [7:0] cmd_inc_a = '0, cmd_inc_b = '0, cmd_repeat = '0;
  logic busy = 0;
  logic cmd_ready, gpu_start, idle;
  logic [4:0] instruction;
  logic [15:0] cpu_data;
  logic [12:0] gpc_val_s, gpc_val_i;
  logic [7:0] gpc_inc_amount_a, gpc_inc_amount_b, repeat_op_amount;
  logic [$clog2(DEPTH):0] queue_count;
`ifdef GPU16_CMDQ_STATS_EN
  logic [15:0] issued_count;
  logic [7:0] timeout_count;
`endif
  int checks = 0;
  int errors = 0;
  int n_starts = 0;

  gpu16_cmd_queue #(.DEPTH(DEPTH), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_instruction(cmd_instruction), .cmd_data(cmd_data), .cmd_gpc_s(cmd_gpc_s),
    .cmd_gpc_i(cmd_gpc_i), .cmd_inc_a(cmd_inc_a), .cmd_inc_b(cmd_inc_b), .cmd_repeat(cmd_repeat),
    .busy(busy), .gpu_start(gpu_start), .instruction(instruction), .cpu_data(cpu_data),
    .gpc_val_s(gpc_val_s), .gpc_val_i(gpc_val_i), .gpc_inc_amount_a(gpc_inc_amount_a),
    .gpc_inc_amount_b(gpc_inc_amount_b), .repeat_op_amount(repeat_op_amount),
    .queue_count(queue_count), .idle(idle)
`ifdef GPU16_CMDQ_STATS_EN
    , .issued_count(issued_count), .timeout_count(timeout_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a plain queue of pending commands plus "what the GPU side is doing" (phase).
  // phase 0 = free, 1 = start pulse out, 2 = waiting for busy (m_t cycles so far), 3 = GPU running.
  gpu16_cmd_t mq[$];
  gpu16_cmd_t m_cur = '0, mc;
  bit m_start = 0, m_idle = 1, m_take;
  int m_phase = 0, m_t = 0;
  logic [15:0] m_issued = '0;
  logic [7:0] m_timeouts = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_cur = '0; m_start = 0; m_idle = 1; m_phase = 0; m_t = 0;
      m_issued = '0; m_timeouts = '0;
    end else begin
      m_take = cmd_valid && mq.size() < DEPTH;
      if (m_start) m_issued = m_issued + 16'd1;
      m_start = 0;
      if (m_phase == 0) begin
        if (mq.size() > 0) begin
          mc = mq.pop_front();
          if (mc.instruction != 5'd0) begin
            m_cur = mc; m_start = 1; m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        m_phase = 2; m_t = 0;
      end else if (m_phase == 2) begin
        m_t++;
        if (busy) m_phase = 3;
        else if (m_t == BUSY_WAIT) begin
          m_phase = 0;
          if (m_timeouts != 8'd255) m_timeouts = m_timeouts + 8'd1;
        end
      end else if (!busy) m_phase = 0;
      if (m_take) mq.push_back({cmd_instruction, cmd_data, cmd_gpc_s, cmd_gpc_i, cmd_inc_a, cmd_inc_b, cmd_repeat});
      m_idle = m_phase == 0 && mq.size() == 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (gpu_start) n_starts++;
    chk("gpu_start", gpu_start, m_start);
    chk("operands", {instruction, cpu_data, gpc_val_s, gpc_val_i, gpc_inc_amount_a,
                     gpc_inc_amount_b, repeat_op_amount}, m_cur);
    chk("queue_count", queue_count, mq.size());
    chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
    chk("idle", idle, m_idle);
`ifdef GPU16_CMDQ_STATS_EN
    chk("issued_count", issued_count, m_issued);
    chk("timeout_count", timeout_count, m_timeouts);
`endif
  end

  task automatic push_cmd(input logic [4:0] ins, input logic [15:0] d, input logic [12:0] s,
                          input logic [12:0] i, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] r);
    int k = 0;
    @(negedge clk);
    cmd_instruction = ins; cmd_data = d; cmd_gpc_s = s; cmd_gpc_i = i;
    cmd_inc_a = a; cmd_inc_b = b; cmd_repeat = r; cmd_valid = 1;
    while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) begin
      checks++; errors++;
      $display("FAIL push_wait: cmd_ready=%0b, expected 1 within 300 cycles", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (!(idle && queue_count == 0) && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) begin
      checks++; errors++;
      $display("FAIL idle_wait: idle=%0b, expected 1 within 300 cycles", idle);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (2) @(negedge clk);
    chk("rst_gpu_start", gpu_start, 0);
    chk("rst_queue_count", queue_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_cpu_data", cpu_data, 0);
    reset = 1;

    // Single command, busy never rises: start pulse one edge after acceptance, then timeout.
    push_cmd(5'd1, 16'h3C00, 13'd0, 13'd0, 8'd0, 8'd0, 8'd0);
    chk("t1_count_after_push", queue_count, 1);
    chk("t1_idle_after_push", idle, 0);
    chk("t1_no_start_yet", gpu_start, 0);
    @(negedge clk);
    chk("t1_start", gpu_start, 1);
    chk("t1_instr", instruction, 5'd1);
    chk("t1_data", cpu_data, 16'h3C00);
    @(negedge clk);
    chk("t1_start_one_cycle", gpu_start, 0);
    repeat (3) @(negedge clk);
    chk("t1_idle_before_timeout", idle, 0);
    @(negedge clk);
    chk("t1_idle_after_timeout", idle, 1);
    chk("t1_operands_held", cpu_data, 16'h3C00);

    // Long busy window, with a second command queued behind it.
    push_cmd(5'd4, 16'h0000, 13'd0, 13'd0, 8'd1, 8'd2, 8'd7);
    @(negedge clk);
    chk("t2_start", gpu_start, 1);
    @(negedge clk);
    busy = 1;
    push_cmd(5'd2, 16'hBEEF, 13'd5, 13'd6, 8'd3, 8'd4, 8'd5);
    repeat (36) @(negedge clk);
    chk("t2_instr_held", instruction, 5'd4);
    chk("t2_inc_a_held", gpc_inc_amount_a, 8'd1);
    chk("t2_inc_b_held", gpc_inc_amount_b, 8'd2);
    chk("t2_repeat_held", repeat_op_amount, 8'd7);
    busy = 0;
    @(negedge clk);
    chk("t2_no_start_1_after_busy_fall", gpu_start, 0);
    @(negedge clk);
    chk("t2_start_2_after_busy_fall", gpu_start, 1);
    chk("t2_next_instr", instruction, 5'd2);
    wait_idle();

    // Fill the queue while one command is held in flight by busy.
    busy = 1;
    push_cmd(5'd3, 16'd1, 13'd1, 13'd1, 8'd1, 8'd1, 8'd1);
    push_cmd(5'd3, 16'd2, 13'd2, 13'd2, 8'd2, 8'd2, 8'd2);
    push_cmd(5'd3, 16'd3, 13'd3, 13'd3, 8'd3, 8'd3, 8'd3);
    push_cmd(5'd3, 16'd4, 13'd4, 13'd4, 8'd4, 8'd4, 8'd4);
    push_cmd(5'd3, 16'd5, 13'd5, 13'd5, 8'd5, 8'd5, 8'd5);
    chk("t3_full_count", queue_count, 4);
    chk("t3_full_ready", cmd_ready, 0);
    cmd_instruction = 5'd9; cmd_data = 16'd6; cmd_valid = 1;
    repeat (5) @(negedge clk);
    chk("t3_blocked_count", queue_count, 4);
    chk("t3_inflight_data", cpu_data, 16'd1);
    busy = 0;
    s0 = 0;
    while (!cmd_ready && s0 < 50) begin @(negedge clk); s0++; end
    chk("t3_ready_after_pop", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    chk("t3_count_after_pop_push", queue_count, 4);
    wait_idle();

    // NOP is dropped silently; only the real command issues.
    s0 = n_starts;
    push_cmd(5'd0, 16'hAAAA, 13'd1, 13'd2, 8'd0, 8'd0, 8'd0);
    push_cmd(5'd6, 16'h1234, 13'd16, 13'd28, 8'd1, 8'd1, 8'd0);
    wait_idle();
    chk("t4_one_start", n_starts - s0, 1);
    chk("t4_instr", instruction, 5'd6);
    chk("t4_gpc_s", gpc_val_s, 13'd16);
    chk("t4_gpc_i", gpc_val_i, 13'd28);

    // Asynchronous reset in the middle of a command with two more queued.
    busy = 1;
    push_cmd(5'd7, 16'h1234, 13'd7, 13'd7, 8'd7, 8'd7, 8'd7);
    push_cmd(5'd8, 16'd8, 13'd8, 13'd8, 8'd8, 8'd8, 8'd8);
    push_cmd(5'd9, 16'd9, 13'd9, 13'd9, 8'd9, 8'd9, 8'd9);
    chk("t5_queued", queue_count, 2);
    chk("t5_inflight", instruction, 5'd7);
    #2 reset = 0;
    #1;
    chk("t5_rst_instr", instruction, 0);
    chk("t5_rst_data", cpu_data, 0);
    chk("t5_rst_count", queue_count, 0);
    chk("t5_rst_start", gpu_start, 0);
    chk("t5_rst_idle", idle, 1);
    @(negedge clk);
    reset = 1;
    busy = 0;
    s0 = n_starts;
    repeat (20) @(negedge clk);
    chk("t5_no_start_after_reset", n_starts - s0, 0);

    // Three commands: two answered by busy, one left to time out.
    busy = 1;
    push_cmd(5'd10, 16'd10, 13'd0, 13'd0, 8'd0, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    busy = 0;
    wait_idle();
    busy = 1;
    push_cmd(5'd11, 16'd11, 13'd0, 13'd0, 8'd0, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    busy = 0;
    wait_idle();
    push_cmd(5'd12, 16'd12, 13'd0, 13'd0, 8'd0, 8'd0, 8'd0);
    wait_idle();
    chk("t6_starts", n_starts - s0, 3);
`ifdef GPU16_CMDQ_STATS_EN
    chk("t6_issued_count", issued_count, 16'd3);
    chk("t6_timeout_count", timeout_count, 8'd1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
